// File: rtl/fmul_issue.sv
// ============================================================================
//  Module      : fmul_issue
//  Description : Issue/collect stage wrapped around a combinational fmul.
//                Registers an operand pair, holds it on the multiplier for a
//                fixed window, then captures and presents the product + tag.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fmul_issue #(
    parameter int LATENCY = 2,
    parameter int TAG_W   = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x,
    input  logic [31:0]      in_y,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      mul_x,
    output logic [31:0]      mul_y,
    input  logic [31:0]      mul_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Loaded on accept so the final WAIT cycle (cnt==0) is the capture cycle.
    localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic [31:0]        r_mul_x;
    logic [31:0]        r_mul_y;
    logic [TAG_W-1:0]   r_op_tag;
    logic [31:0]        r_out_res;
    logic [TAG_W-1:0]   r_out_tag;
    logic               w_accept;

    assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
    assign w_accept  = in_valid & in_ready & ~flush;

    assign mul_x     = r_mul_x;
    assign mul_y     = r_mul_y;
    assign out_res   = r_out_res;
    assign out_tag   = r_out_tag;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_mul_x   <= 32'd0;
            r_mul_y   <= 32'd0;
            r_op_tag  <= '0;
            r_out_res <= 32'd0;
            r_out_tag <= '0;
        end else if (flush) begin
            // Operand and result registers keep their contents; only the
            // control state forgets the op.
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else if (w_accept) begin
            r_mul_x  <= in_x;
            r_mul_y  <= in_y;
            r_op_tag <= in_tag;
            r_cnt    <= c_CNT_INIT;
            r_state  <= S_WAIT;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_IDLE;
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_out_res <= mul_res;
                        r_out_tag <= r_op_tag;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fmul_issue.sv
// ============================================================================
//  Module      : tb_fmul_issue
//  Description : Self-checking bench for fmul_issue with a lookup fmul model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fmul_issue;

    localparam int LATENCY = 2;
    localparam int TAG_W   = 6;

    logic             clk;
    logic             rstn;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_x;
    logic [31:0]      in_y;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      mul_x;
    logic [31:0]      mul_y;
    logic [31:0]      mul_res;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_res;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    fmul_issue #(.LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_tag    (in_tag),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_res   (mul_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the fmul datapath: exact products for the operands used here.
    function automatic logic [31:0] fmul_model(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] key;
        key = {x, y};
        case (key)
            {32'h3FC00000, 32'h40000000}: return 32'h40400000;
            {32'hC0000000, 32'h40400000}: return 32'hC0C00000;
            {32'h3F800000, 32'h3F800000}: return 32'h3F800000;
            {32'h40800000, 32'h3F000000}: return 32'h40000000;
            {32'h40400000, 32'h40400000}: return 32'h41100000;
            {32'h00800000, 32'h00800000}: return 32'h00000000;
            default:                      return x ^ y;
        endcase
    endfunction

    always_comb mul_res = fmul_model(mul_x, mul_y);

    typedef struct {
        logic [31:0]      x;
        logic [31:0]      y;
        logic [TAG_W-1:0] tag;
        logic [31:0]      res;
    } vec_t;

    typedef struct packed {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_pop(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: result with empty scoreboard, got %h", name, out_res);
        end else begin
            e = sb.pop_front();
            check({name, "_res"}, out_res, e.res);
            check({name, "_tag"}, 32'(out_tag), 32'(e.tag));
        end
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send(input vec_t v, input bit push);
        int k;
        in_x = v.x; in_y = v.y; in_tag = v.tag; in_valid = 1'b1;
        #1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        if (k >= 50) check("send_timeout", 32'(in_ready), 32'd1);
        if (push) sb.push_back({v.res, v.tag});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) check("valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic collect(input string name);
        compare_pop(name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int k;
        send(v, 1'b1);
        check({name, "_mulx"}, mul_x, v.x);
        check({name, "_muly"}, mul_y, v.y);
        wait_valid(k);
        check({name, "_lat"}, 32'(k), 32'(LATENCY));
        collect(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        vec_t v;
        int   k, k2;
        bit   seen;

        vecs[0] = '{32'h3FC00000, 32'h40000000, 6'd5,  32'h40400000};
        vecs[1] = '{32'hC0000000, 32'h40400000, 6'd12, 32'hC0C00000};
        vecs[2] = '{32'h3F800000, 32'h3F800000, 6'd63, 32'h3F800000};
        vecs[3] = '{32'h40800000, 32'h3F000000, 6'd0,  32'h40000000};
        vecs[4] = '{32'h40400000, 32'h40400000, 6'd33, 32'h41100000};

        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_x = 32'd0; in_y = 32'd0; in_tag = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_mul_x",     mul_x,          32'd0);
        check("rst_out_res",   out_res,        32'd0);
        check("rst_out_tag",   32'(out_tag),   32'd0);
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Stall in DONE: result held, input side blocked even with in_valid high.
        v = '{32'hC0000000, 32'h40400000, 6'd9, 32'hC0C00000};
        send(v, 1'b1);
        wait_valid(k);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_x = 32'h12345678; in_y = 32'h9ABCDEF0; in_tag = 6'd1;
            #1;
            check("stall_res",      out_res,          32'hC0C00000);
            check("stall_tag",      32'(out_tag),     32'd9);
            check("stall_in_ready", 32'(in_ready),    32'd0);
            check("stall_valid",    32'(out_valid),   32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        collect("stall");

        // Back-to-back with in_valid and out_ready held high.
        out_ready = 1'b1;
        in_x = 32'h3F800000; in_y = 32'h3F800000; in_tag = 6'd21; in_valid = 1'b1;
        #1;
        check("b2b_ready0", 32'(in_ready), 32'd1);
        sb.push_back({32'h3F800000, 6'd21});
        @(negedge clk);
        in_x = 32'h40800000; in_y = 32'h3F000000; in_tag = 6'd22;
        wait_valid(k);
        check("b2b_lat1", 32'(k), 32'(LATENCY));
        #1;
        check("b2b_ready_done", 32'(in_ready), 32'd1);
        compare_pop("b2b_op1");
        sb.push_back({32'h40000000, 6'd22});
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(k2);
        check("b2b_gap", 32'(k2 + 1), 32'(LATENCY + 1));
        compare_pop("b2b_op2");
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("b2b_idle", 32'(busy), 32'd0);
        @(negedge clk);

        // Flush the cycle after accept: op never emerges.
        send(vecs[0], 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flushw_busy", 32'(busy), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("flushw_no_valid", 32'(seen), 32'd0);
        run_vec('{32'h40400000, 32'h40400000, 6'd17, 32'h41100000}, "post_flush");

        // Flush together with in_valid in IDLE: nothing accepted.
        in_x = 32'h3F800000; in_y = 32'h3F800000; in_tag = 6'd2;
        in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flushi_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("flushi_busy2", 32'(busy), 32'd0);

        // Flush in DONE beats out_ready.
        send(vecs[2], 1'b0);
        wait_valid(k);
        out_ready = 1'b1; flush = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; flush = 1'b0;
        check("flushd_valid", 32'(out_valid), 32'd0);
        check("flushd_busy",  32'(busy),      32'd0);
        @(negedge clk);

        // Reset in DONE, then tiny operands.
        send(vecs[4], 1'b0);
        wait_valid(k);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        #1;
        check("rstd_valid",    32'(out_valid), 32'd0);
        check("rstd_out_res",  out_res,        32'd0);
        check("rstd_in_ready", 32'(in_ready),  32'd1);
        rstn = 1'b1;
        @(negedge clk);
        run_vec('{32'h00800000, 32'h00800000, 6'd3, 32'h00000000}, "tiny");

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
